// File: rtl/camera_stream_tx_pkg.sv
// Shared definitions for the camera stream transmitter and its timing generator.
// Holds the default frame geometry, the FSM state encoding and small pixel
// helpers (RGB565 byte split and RGB565 -> RGB332 reduction used by the
// capture side).
package camera_stream_tx_pkg;

  localparam int SCREEN_WIDTH  = 176;
  localparam int SCREEN_HEIGHT = 144;
  localparam int PIX_ADDR_W    = 15;
  localparam int PIX_DATA_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLK   = 3'd4,
    ST_VFRONT = 3'd5
  } cam_state_t;

  function automatic logic [7:0] rgb565_hi(input logic [15:0] px);
    return px[15:8];
  endfunction

  function automatic logic [7:0] rgb565_lo(input logic [15:0] px);
    return px[7:0];
  endfunction

  // Keeps the top bits of each colour channel: RRR GGG BB.
  function automatic logic [7:0] rgb565_to_rgb332(input logic [15:0] px);
    return {px[15:13], px[10:8], px[4:3]};
  endfunction

endpackage

// File: rtl/camera_stream_tx_timing_gen.sv
// Frame/line timing generator for the parallel camera transmitter.
// Runs the IDLE/VSYNC/V_BACK/ACTIVE/H_BLK/V_FRONT state machine and its
// counters, drives the registered sync outputs and gives the data path
// look-ahead strobes for the next cycle.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_en                start/continue streaming (sampled in IDLE and at frame end)
//   o_vsync, o_href     registered sync outputs
//   o_frame_done        registered pulse on the last cycle of V_FRONT
//   o_busy              registered, high outside IDLE
//   o_href_next         HREF value that the coming edge will register
//   o_byte_phase_next   byte phase (0 = high byte) the coming edge will register
//   o_pixel_advance     coming edge must step the pixel address by one
//   o_addr_rewind       coming edge must return the pixel address to 0
module camera_stream_tx_timing_gen
  import camera_stream_tx_pkg::*;
#(
  parameter int WIDTH         = SCREEN_WIDTH,
  parameter int HEIGHT        = SCREEN_HEIGHT,
  parameter int H_BLANK       = 16,
  parameter int V_SYNC_LINES  = 3,
  parameter int V_BACK_LINES  = 2,
  parameter int V_FRONT_LINES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_vsync,
  output logic o_href,
  output logic o_frame_done,
  output logic o_busy,
  output logic o_href_next,
  output logic o_byte_phase_next,
  output logic o_pixel_advance,
  output logic o_addr_rewind
);

  localparam int LINE_CYC = 2 * WIDTH + H_BLANK;
  localparam int MAX_BL   = (V_SYNC_LINES > V_BACK_LINES) ?
                            ((V_SYNC_LINES > V_FRONT_LINES) ? V_SYNC_LINES : V_FRONT_LINES) :
                            ((V_BACK_LINES > V_FRONT_LINES) ? V_BACK_LINES : V_FRONT_LINES);
  localparam int CYC_W    = $clog2(LINE_CYC + 1);
  localparam int BYTE_W   = $clog2(2 * WIDTH + 1);
  localparam int LINE_W   = $clog2(HEIGHT + 1);
  localparam int BL_W     = $clog2(MAX_BL + 1);

  localparam logic [CYC_W-1:0]  CYC_LAST     = CYC_W'(LINE_CYC - 1);
  localparam logic [CYC_W-1:0]  CYC_PRE      = CYC_W'(LINE_CYC - 2);
  localparam logic [CYC_W-1:0]  HB_LAST      = CYC_W'(H_BLANK - 1);
  localparam logic [CYC_W-1:0]  HB_PRE       = CYC_W'(H_BLANK - 2);
  localparam logic [BYTE_W-1:0] BYTE_LAST    = BYTE_W'(2 * WIDTH - 1);
  localparam logic [BYTE_W-1:0] BYTE_LASTPIX = BYTE_W'(2 * WIDTH - 2);
  localparam logic [LINE_W-1:0] LINE_LAST    = LINE_W'(HEIGHT - 1);
  localparam logic [BL_W-1:0]   VS_LAST      = BL_W'(V_SYNC_LINES - 1);
  localparam logic [BL_W-1:0]   VB_LAST      = BL_W'(V_BACK_LINES - 1);
  localparam logic [BL_W-1:0]   VF_LAST      = BL_W'(V_FRONT_LINES - 1);

  cam_state_t        r_state, w_state_next;
  logic [CYC_W-1:0]  r_cyc,   w_cyc_next;
  logic [BYTE_W-1:0] r_byte,  w_byte_next;
  logic [LINE_W-1:0] r_line,  w_line_next;
  logic [BL_W-1:0]   r_blank, w_blank_next;
  logic              w_frame_end;
  logic              w_line_prefetch;
  logic              w_frame_prefetch;

  logic r_vsync, r_href, r_frame_done, r_busy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cyc        <= '0;
      r_byte       <= '0;
      r_line       <= '0;
      r_blank      <= '0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cyc        <= w_cyc_next;
      r_byte       <= w_byte_next;
      r_line       <= w_line_next;
      r_blank      <= w_blank_next;
      r_vsync      <= (w_state_next == ST_VSYNC);
      r_href       <= (w_state_next == ST_ACTIVE);
      r_busy       <= (w_state_next != ST_IDLE);
      r_frame_done <= (w_state_next == ST_VFRONT) && (w_blank_next == VF_LAST) &&
                      (w_cyc_next == CYC_LAST);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cyc_next   = r_cyc;
    w_byte_next  = r_byte;
    w_line_next  = r_line;
    w_blank_next = r_blank;
    w_frame_end  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en) w_state_next = ST_VSYNC;
      end
      ST_VSYNC: begin
        if (r_cyc == CYC_LAST) begin
          w_cyc_next = '0;
          if (r_blank == VS_LAST) begin
            w_blank_next = '0;
            w_state_next = ST_VBACK;
          end else begin
            w_blank_next = r_blank + 1'b1;
          end
        end else begin
          w_cyc_next = r_cyc + 1'b1;
        end
      end
      ST_VBACK: begin
        if (r_cyc == CYC_LAST) begin
          w_cyc_next = '0;
          if (r_blank == VB_LAST) begin
            w_blank_next = '0;
            w_state_next = ST_ACTIVE;
          end else begin
            w_blank_next = r_blank + 1'b1;
          end
        end else begin
          w_cyc_next = r_cyc + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (r_byte == BYTE_LAST) begin
          w_byte_next  = '0;
          w_state_next = ST_HBLK;
        end else begin
          w_byte_next = r_byte + 1'b1;
        end
      end
      ST_HBLK: begin
        if (r_cyc == HB_LAST) begin
          w_cyc_next = '0;
          if (r_line == LINE_LAST) begin
            w_line_next  = '0;
            w_state_next = ST_VFRONT;
          end else begin
            w_line_next  = r_line + 1'b1;
            w_state_next = ST_ACTIVE;
          end
        end else begin
          w_cyc_next = r_cyc + 1'b1;
        end
      end
      ST_VFRONT: begin
        if (r_cyc == CYC_LAST) begin
          w_cyc_next = '0;
          if (r_blank == VF_LAST) begin
            w_blank_next = '0;
            w_frame_end  = 1'b1;
            w_state_next = i_en ? ST_VSYNC : ST_IDLE;
          end else begin
            w_blank_next = r_blank + 1'b1;
          end
        end else begin
          w_cyc_next = r_cyc + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // The first pixel of a line must be addressed two edges before ACTIVE is
  // entered, i.e. on the edge that moves the blank counter to its
  // second-to-last value. Using next-state values keeps this correct when
  // H_BLANK is exactly 2 and that edge is the one leaving ACTIVE.
  always_comb begin
    w_line_prefetch  = (w_state_next == ST_HBLK) && (w_cyc_next == HB_PRE) &&
                       (w_line_next != LINE_LAST);
    w_frame_prefetch = (w_state_next == ST_VBACK) && (w_blank_next == VB_LAST) &&
                       (w_cyc_next == CYC_PRE);
  end

  assign o_href_next       = (w_state_next == ST_ACTIVE);
  assign o_byte_phase_next = w_byte_next[0];
  // Each high-byte load steps to the next pixel in the line; the last pixel
  // leaves the step to the H_BLK prefetch.
  assign o_pixel_advance   = (o_href_next && !w_byte_next[0] && (w_byte_next != BYTE_LASTPIX)) ||
                             w_line_prefetch;
  assign o_addr_rewind     = w_frame_end || w_frame_prefetch;

  assign o_vsync      = r_vsync;
  assign o_href       = r_href;
  assign o_frame_done = r_frame_done;
  assign o_busy       = r_busy;

endmodule

// File: rtl/camera_stream_tx.sv
// OV7670-style parallel pixel transmitter (VSYNC/HREF/8-bit DATA).
// Reads RGB565 pixels from a synchronous-read frame memory and emits each
// pixel as two bytes, high byte first, with frame and line timing.
// Ports:
//   i_clk          byte clock
//   i_rst          asynchronous active-high reset
//   i_en           start/continue streaming frames
//   o_pix_addr     frame memory read address (y*WIDTH + x, built incrementally)
//   i_pix_data     RGB565 word, valid one clock after o_pix_addr is sampled
//   o_vsync        high during the vertical-sync period
//   o_href         high while o_data carries active bytes
//   o_data         pixel byte, 0 whenever o_href is low
//   o_frame_done   one-clock pulse on the last cycle of V_FRONT
//   o_busy         high in every state except IDLE
module camera_stream_tx
  import camera_stream_tx_pkg::*;
#(
  parameter int WIDTH         = SCREEN_WIDTH,
  parameter int HEIGHT        = SCREEN_HEIGHT,
  parameter int H_BLANK       = 16,
  parameter int V_SYNC_LINES  = 3,
  parameter int V_BACK_LINES  = 2,
  parameter int V_FRONT_LINES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  output logic [PIX_ADDR_W-1:0] o_pix_addr,
  input  logic [PIX_DATA_W-1:0] i_pix_data,
  output logic                  o_vsync,
  output logic                  o_href,
  output logic [7:0]            o_data,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  localparam logic [PIX_ADDR_W-1:0] ADDR_LAST = PIX_ADDR_W'(WIDTH * HEIGHT - 1);

  logic w_href_next;
  logic w_byte_phase_next;
  logic w_pixel_advance;
  logic w_addr_rewind;

  logic [PIX_ADDR_W-1:0] r_pix_addr;
  logic [7:0]            r_hold_lo;
  logic [7:0]            r_data;

  camera_stream_tx_timing_gen #(
    .WIDTH         (WIDTH),
    .HEIGHT        (HEIGHT),
    .H_BLANK       (H_BLANK),
    .V_SYNC_LINES  (V_SYNC_LINES),
    .V_BACK_LINES  (V_BACK_LINES),
    .V_FRONT_LINES (V_FRONT_LINES)
  ) u_timing (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_en              (i_en),
    .o_vsync           (o_vsync),
    .o_href            (o_href),
    .o_frame_done      (o_frame_done),
    .o_busy            (o_busy),
    .o_href_next       (w_href_next),
    .o_byte_phase_next (w_byte_phase_next),
    .o_pixel_advance   (w_pixel_advance),
    .o_addr_rewind     (w_addr_rewind)
  );

  // On the high-byte edge the memory word goes straight out as the high byte
  // and only its low half is held for the following edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pix_addr <= '0;
      r_hold_lo  <= '0;
      r_data     <= '0;
    end else begin
      if (w_href_next) begin
        if (!w_byte_phase_next) begin
          r_hold_lo <= rgb565_lo(i_pix_data);
          r_data    <= rgb565_hi(i_pix_data);
        end else begin
          r_data    <= r_hold_lo;
        end
      end else begin
        r_data <= '0;
      end

      if (w_addr_rewind) begin
        r_pix_addr <= '0;
      end else if (w_pixel_advance) begin
        r_pix_addr <= (r_pix_addr == ADDR_LAST) ? '0 : r_pix_addr + 1'b1;
      end
    end
  end

  assign o_pix_addr = r_pix_addr;
  assign o_data     = r_data;

endmodule
